// File: rtl/alu_instr_decoder_if.sv
// alu_instr_decoder_if: upstream instruction and downstream decoded-field handshakes
interface alu_instr_decoder_if #(parameter int CNT_W = 8);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             dec_valid;
  logic             dec_ready;
  logic [4:0]       RS1;
  logic [4:0]       RS2;
  logic [4:0]       RD;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic [11:0]      imm;
  logic             is_imm;
  logic [CNT_W-1:0] illegal_cnt;
  modport slave (
    input  instr_valid, instr, dec_ready,
    output instr_ready, dec_valid, RS1, RS2, RD, Funct3, Funct7, imm, is_imm, illegal_cnt
  );
  modport master (
    output instr_valid, instr, dec_ready,
    input  instr_ready, dec_valid, RS1, RS2, RD, Funct3, Funct7, imm, is_imm, illegal_cnt
  );
endinterface

// File: rtl/alu_instr_decoder.sv
// alu_instr_decoder: decodes RV32I OP/OP-IMM words into a FIFO of ALU fields, counting illegal words
module alu_instr_decoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  alu_instr_decoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic        is_imm;
  } entry_t;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           ent;
  entry_t           head;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d, count;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       op, f7;
  logic [2:0]       f3;
  logic             is_r, is_i, legal, accept, push, pop;
  // decode the incoming word and check legality; shifts keep funct7, other OP-IMM zero it
  always_comb begin
    op = bus.instr[6:0];
    f3 = bus.instr[14:12];
    f7 = bus.instr[31:25];
    is_r = op == 7'b0110011 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
    is_i = op == 7'b0010011 && (f3 == 3'b001 ? f7 == 7'h00 :
                                f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
    legal = is_r | is_i;
    ent = '0;
    ent.rs1 = bus.instr[19:15];
    ent.rs2 = is_i ? 5'd0 : bus.instr[24:20];
    ent.rd = bus.instr[11:7];
    ent.f3 = f3;
    ent.f7 = (is_i && f3 != 3'b001 && f3 != 3'b101) ? 7'd0 : f7;
    ent.imm = is_i ? bus.instr[31:20] : 12'd0;
    ent.is_imm = is_i;
  end
  // handshakes, FIFO pointer/storage next state and saturating illegal counter
  always_comb begin
    count = wr_q - rd_q;
    bus.instr_ready = rst & (count < FULL);
    bus.dec_valid = count != '0;
    accept = bus.instr_valid & bus.instr_ready;
    push = accept & legal;
    pop = bus.dec_valid & bus.dec_ready;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = ent;
    cnt_d = (accept & ~legal & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    head = mem_q[rd_q[AW-1:0]];
  end
  assign bus.RS1 = head.rs1;
  assign bus.RS2 = head.rs2;
  assign bus.RD = head.rd;
  assign bus.Funct3 = head.f3;
  assign bus.Funct7 = head.f7;
  assign bus.imm = head.imm;
  assign bus.is_imm = head.is_imm;
  assign bus.illegal_cnt = cnt_q;
  // state registers; async reset discards all queued entries and the counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_alu_instr_decoder.sv
// tb_alu_instr_decoder: directed self-checking bench for alu_instr_decoder
module tb_alu_instr_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  alu_instr_decoder_if #(.CNT_W(8)) bus ();
  alu_instr_decoder #(.DEPTH(2), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    bus.dec_ready = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_valid", 32'(bus.dec_valid), 0);
    chk("rst_cnt", 32'(bus.illegal_cnt), 0);
    chk("rst_rs1", 32'(bus.RS1), 0);
    chk("rst_imm", 32'(bus.imm), 0);
    rst = 1'b1;
    step();
    chk("ready_after_rst", 32'(bus.instr_ready), 1);
    // sub x10,x10,x11
    bus.dec_ready = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr = 32'h40B50533;
    step();
    bus.instr_valid = 1'b0;
    chk("sub_valid", 32'(bus.dec_valid), 1);
    chk("sub_rs1", 32'(bus.RS1), 10);
    chk("sub_rs2", 32'(bus.RS2), 11);
    chk("sub_rd", 32'(bus.RD), 10);
    chk("sub_f3", 32'(bus.Funct3), 0);
    chk("sub_f7", 32'(bus.Funct7), 32'h20);
    chk("sub_isimm", 32'(bus.is_imm), 0);
    chk("sub_imm", 32'(bus.imm), 0);
    step();
    chk("sub_popped", 32'(bus.dec_valid), 0);
    // addi x10,x10,-1 then srai x10,x10,1 back to back while popping
    bus.instr_valid = 1'b1;
    bus.instr = 32'hFFF50513;
    step();
    bus.instr = 32'h40155513;
    chk("addi_imm", 32'(bus.imm), 32'hFFF);
    chk("addi_rs2", 32'(bus.RS2), 0);
    chk("addi_f7", 32'(bus.Funct7), 0);
    chk("addi_isimm", 32'(bus.is_imm), 1);
    step();
    bus.instr_valid = 1'b0;
    chk("srai_valid", 32'(bus.dec_valid), 1);
    chk("srai_f7", 32'(bus.Funct7), 32'h20);
    chk("srai_imm", 32'(bus.imm), 32'h401);
    chk("srai_f3", 32'(bus.Funct3), 5);
    step();
    chk("srai_popped", 32'(bus.dec_valid), 0);
    // fill: add x1,x2,x3 / addi x5,x0,7 / xor x6,x7,x8 with the ALU stalled
    bus.dec_ready = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr = 32'h003100B3;
    step();
    chk("fill1_ready", 32'(bus.instr_ready), 1);
    bus.instr = 32'h00700293;
    step();
    chk("full_ready", 32'(bus.instr_ready), 0);
    chk("full_head_rd", 32'(bus.RD), 1);
    bus.instr = 32'h0083C333;
    step();
    chk("full_hold_ready", 32'(bus.instr_ready), 0);
    chk("full_hold_rd", 32'(bus.RD), 1);
    chk("full_hold_rs2", 32'(bus.RS2), 3);
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
    chk("pop1_ready", 32'(bus.instr_ready), 1);
    chk("pop1_head_rd", 32'(bus.RD), 5);
    chk("pop1_head_imm", 32'(bus.imm), 7);
    step();
    bus.instr_valid = 1'b0;
    chk("third_in_ready", 32'(bus.instr_ready), 0);
    chk("third_in_head", 32'(bus.RD), 5);
    bus.dec_ready = 1'b1;
    step();
    chk("pop2_rd", 32'(bus.RD), 6);
    chk("pop2_f3", 32'(bus.Funct3), 4);
    chk("pop2_rs1", 32'(bus.RS1), 7);
    chk("pop2_rs2", 32'(bus.RS2), 8);
    step();
    chk("drained", 32'(bus.dec_valid), 0);
    // illegal words: ecall and funct7 0x20 on SLL, then saturation
    bus.dec_ready = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr = 32'h00000073;
    step();
    bus.instr = 32'h40001033;
    step();
    bus.instr_valid = 1'b0;
    chk("ill_no_valid", 32'(bus.dec_valid), 0);
    chk("ill_cnt2", 32'(bus.illegal_cnt), 2);
    chk("ill_ready", 32'(bus.instr_ready), 1);
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 260; i++) step();
    bus.instr_valid = 1'b0;
    chk("ill_sat", 32'(bus.illegal_cnt), 32'hFF);
    chk("ill_sat_no_valid", 32'(bus.dec_valid), 0);
    // one entry held, push+pop each cycle across pointer wrap
    bus.instr_valid = 1'b1;
    bus.instr = (32'd100 << 20) | 32'h00000093;
    step();
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.instr = (32'(101 + i) << 20) | 32'h00000093;
      chk("wrap_head", 32'(bus.imm), 32'(100 + i));
      step();
      chk("wrap_valid", 32'(bus.dec_valid), 1);
      chk("wrap_ready", 32'(bus.instr_ready), 1);
    end
    bus.instr_valid = 1'b0;
    chk("wrap_last", 32'(bus.imm), 108);
    step();
    chk("wrap_drained", 32'(bus.dec_valid), 0);
    // reset mid-stream with two entries queued
    bus.dec_ready = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr = 32'h003100B3;
    step();
    bus.instr = 32'h00700293;
    step();
    bus.instr_valid = 1'b0;
    chk("pre_rst_full", 32'(bus.instr_ready), 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.dec_valid), 0);
    chk("mid_rst_cnt", 32'(bus.illegal_cnt), 0);
    chk("mid_rst_ready", 32'(bus.instr_ready), 0);
    chk("mid_rst_rd", 32'(bus.RD), 0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.instr_ready), 1);
    chk("post_rst_valid", 32'(bus.dec_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
